dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-bus responder for the single-cycle RISC-V core: the slave end of the core's `daddr`/`ddata_w`/`d_w`/`d_r`/`ddata_r` data interface. It decodes each word address into one of two regions:
- **Data RAM:** combinational read, synchronous write.
- **MMIO block:** GPIO, a free-running timer with compare interrupt, and a 4-entry byte FIFO feeding a downstream UART transmitter over a valid/ready handshake.

## Interface
Parameters:
- `RAM_WORDS`, 768 — RAM depth in 32-bit words; occupies word addresses 0x000..RAM_WORDS-1 (max 768).
- `GPIO_W`, 8 — width of the GPIO in/out ports (1..32).
- `FIFO_DEPTH`, 4 — TX FIFO entries; must be a power of two.

Ports:
- `CLK`  in  1  — single clock, all state on rising edge.
- `RSTn`  in  1  — reset, synchronous and active-low.
- `daddr`  in  10  — word address from core.
- `ddata_w`  in  32  — write data.
- `d_w`  in  1  — write strobe, sampled at rising edge.
- `d_r`  in  1  — read enable.
- `ddata_r`  out  32  — read data, combinational.
- `gpio_i`  in  GPIO_W  — asynchronous external inputs.
- `gpio_o`  out  GPIO_W  — GPIO output register.
- `tx_data`  out  8  — FIFO head byte.
- `tx_valid`  out  1  — FIFO non-empty.
- `tx_ready`  in  1  — downstream accepts `tx_data` when high with `tx_valid`.
- `irq`  out  1  — `match_flag & irq_en`, registered.

## Operation
- **Decode:**
  - `daddr[9:8]==2'b11` selects MMIO at offset `daddr[7:0]`.
  - Any other address below RAM_WORDS selects RAM.
  - RAM addresses at or above RAM_WORDS read 0; writes to them are ignored.
- **RAM:**
  - Write: `mem[daddr] <= ddata_w` when `d_w`.
  - Read: `ddata_r = mem[daddr]` when `d_r`.
  - Contents are not cleared by reset.
- **`ddata_r` gating:** `ddata_r = 0` whenever `d_r` is low.
- **Read/write collision:** when `d_r` and `d_w` are both high, the read returns the pre-write value and the write completes at the edge.
- **MMIO map:** unmapped offsets read 0; writes to them are ignored.
  - 0x00 GPIO_OUT (R/W): drives `gpio_o`; bits above GPIO_W read 0.
  - 0x01 GPIO_IN (RO): `gpio_i` after a 2-flop synchronizer, zero-extended.
  - 0x02 TIMER (R/W):
    - Increments every cycle and wraps 0xFFFFFFFF→0.
    - A write loads `ddata_w`; on that cycle the write wins over the increment.
  - 0x03 TIMER_CMP (R/W).
  - 0x04 STATUS:
    - bit0 match_flag, write-1-to-clear.
    - bit1 fifo_full (RO).
    - bit2 fifo_empty (RO).
    - bit3 overflow, write-1-to-clear.
    - bit4 irq_en (R/W).
  - 0x05 TX_DATA (WO, reads 0): a write pushes `ddata_w[7:0]` into the FIFO.
- **Timer match:**
  - When TIMER == TIMER_CMP (pre-increment value), match_flag sets at the next edge.
  - If a set and a W1C clear of match_flag occur in the same cycle, the set wins.
- **FIFO:**
  - Circular buffer with read/write pointers and a count.
  - Push accepted if not full, or if a pop occurs in the same cycle.
  - A rejected push leaves the FIFO unchanged and sets overflow; if set and W1C clear coincide, the set wins.
  - Pop occurs when `tx_valid & tx_ready`.
  - Pointers wrap modulo FIFO_DEPTH.
- **Head/valid outputs:** `tx_data` is the head entry (combinational from storage); `tx_valid = (count != 0)`.

## Timing
- **Reset values** (when `RSTn` is low at an edge):
  - `gpio_o`=0, TIMER=0, TIMER_CMP=0xFFFFFFFF.
  - match_flag=0, overflow=0, irq_en=0.
  - FIFO empty, `tx_valid`=0, `irq`=0.
  - Synchronizer flops=0.
- **Outputs during reset:** `ddata_r` follows the decode rules (combinational) even while in reset.
- **Read latency:** 0 cycles; the core samples `ddata_r` in the same cycle it asserts `d_r`.
- **Write latency:** visible to a read in the following cycle.
- **TIMER read:** returns the current register value; a write of V at edge k reads V at cycle k+1, then V+1 at k+2.
- **GPIO_IN latency:** reflects a `gpio_i` change 2 edges later.
- **match_flag / irq latency:**
  - match_flag is visible 1 edge after the match cycle.
  - `irq` rises 1 edge after (match_flag & irq_en) becomes true.
  - `irq` clears 1 edge after the W1C write.
- **FIFO latencies:**
  - Push → `tx_valid` high after 1 edge.
  - A pop advances `tx_data` at the same edge.
  - fifo_full/fifo_empty update at the edge of the push or pop.
- **Handshake:** `tx_data` is stable while `tx_valid & !tx_ready`.

## Test plan
- **Reset/idle:**
  - Assert `RSTn`=0 for 2 cycles → all outputs at reset values.
  - Read 0x304 → 0x00000004 (empty only).
- **RAM:**
  - Write 0xDEADBEEF @0x010, read @0x010 next cycle → 0xDEADBEEF.
  - Read @0x2FF with `d_r`=0 → 0.
  - Read @0x3F0 → 0.
- **Timer:**
  - Write TIMER=0xFFFFFFFE, CMP=0x00000001, irq_en=1.
  - → TIMER wraps to 0.
  - → match_flag set 1 edge after TIMER==1; `irq` high 1 edge later.
  - Write STATUS=0x11 → `irq` low next edge.
- **FIFO fill/overflow:**
  - With `tx_ready`=0, push 0x41..0x45.
  - → fifo_full after the 4th push; 5th push sets overflow.
  - → `tx_data`=0x41 held stable.
- **Drain + simultaneous push/pop:**
  - With the FIFO full, raise `tx_ready` while pushing 0x46.
  - → 0x41 popped and 0x46 accepted, no overflow.
  - → output order 0x42, 0x43, 0x44, 0x46.
- **GPIO:**
  - Write GPIO_OUT=0x1A5 → `gpio_o`=0xA5.
  - Drive `gpio_i`=0x3C → GPIO_IN reads 0x3C from the 2nd edge on.
  - Reset mid-drain → FIFO empty, `tx_valid`=0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the core data bus.
// Decodes word addresses into a data RAM and an MMIO block
// (GPIO, free-running timer with compare interrupt, UART TX byte FIFO).
module dmem_responder #(
   parameter int unsigned RAM_WORDS  = 768,
   parameter int unsigned GPIO_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic [9:0]        daddr,
   input  logic [31:0]       ddata_w,
   input  logic              d_w,
   input  logic              d_r,
   output logic [31:0]       ddata_r,
   input  logic [GPIO_W-1:0] gpio_i,
   output logic [GPIO_W-1:0] gpio_o,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              irq
);

   localparam int unsigned RAM_AW  = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int unsigned FIFO_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned FIFO_CW = FIFO_PW + 1;

   localparam logic [7:0] OFS_GPIO_OUT  = 8'h00;
   localparam logic [7:0] OFS_GPIO_IN   = 8'h01;
   localparam logic [7:0] OFS_TIMER     = 8'h02;
   localparam logic [7:0] OFS_TIMER_CMP = 8'h03;
   localparam logic [7:0] OFS_STATUS    = 8'h04;
   localparam logic [7:0] OFS_TX_DATA   = 8'h05;

   // Storage (not reset)
   logic [31:0] mem      [RAM_WORDS];
   logic [7:0]  fifo_mem [FIFO_DEPTH];

   // Registered state
   logic [GPIO_W-1:0]  gpio_out_q, gpio_out_d;
   logic [GPIO_W-1:0]  sync1_q, sync2_q;
   logic [31:0]        timer_q, timer_d;
   logic [31:0]        cmp_q, cmp_d;
   logic               match_q, match_d;
   logic               ovf_q, ovf_d;
   logic               irq_en_q, irq_en_d;
   logic               irq_q, irq_d;
   logic [FIFO_PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_CW-1:0] count_q, count_d;

   // Decode
   logic              mmio_sel;
   logic              ram_sel;
   logic [RAM_AW-1:0] ram_idx;
   logic [7:0]        mmio_ofs;
   logic              mmio_wr;
   logic              ram_wr;

   // FIFO control
   logic fifo_full;
   logic fifo_empty;
   logic push_req;
   logic push_ok;
   logic pop;

   // Address decode: top quarter of the word space is MMIO, RAM below its depth
   always_comb begin
      mmio_sel = (daddr[9:8] == 2'b11);
      ram_sel  = !mmio_sel && (32'(daddr) < RAM_WORDS);
      ram_idx  = RAM_AW'(daddr);
      mmio_ofs = daddr[7:0];
      mmio_wr  = d_w && mmio_sel;
      ram_wr   = d_w && ram_sel;
   end

   // FIFO status and handshake; a push into a full FIFO is legal when a pop frees a slot
   always_comb begin
      fifo_full  = (count_q == FIFO_CW'(FIFO_DEPTH));
      fifo_empty = (count_q == '0);
      pop        = tx_valid && tx_ready;
      push_req   = mmio_wr && (mmio_ofs == OFS_TX_DATA);
      push_ok    = push_req && (!fifo_full || pop);
   end

   // Combinational read mux, zero whenever d_r is low
   always_comb begin
      ddata_r = '0;
      if (d_r) begin
         if (ram_sel) begin
            ddata_r = mem[ram_idx];
         end else if (mmio_sel) begin
            case (mmio_ofs)
               OFS_GPIO_OUT:  ddata_r = 32'(gpio_out_q);
               OFS_GPIO_IN:   ddata_r = 32'(sync2_q);
               OFS_TIMER:     ddata_r = timer_q;
               OFS_TIMER_CMP: ddata_r = cmp_q;
               OFS_STATUS:    ddata_r = {27'd0, irq_en_q, ovf_q, fifo_empty, fifo_full, match_q};
               default:       ddata_r = '0;
            endcase
         end
      end
   end

   // Next-state logic for all MMIO registers
   always_comb begin
      gpio_out_d = gpio_out_q;
      timer_d    = timer_q + 32'd1;
      cmp_d      = cmp_q;
      match_d    = match_q;
      ovf_d      = ovf_q;
      irq_en_d   = irq_en_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      irq_d      = match_q && irq_en_q;

      if (mmio_wr) begin
         case (mmio_ofs)
            OFS_GPIO_OUT:  gpio_out_d = ddata_w[GPIO_W-1:0];
            OFS_TIMER:     timer_d    = ddata_w;
            OFS_TIMER_CMP: cmp_d      = ddata_w;
            OFS_STATUS: begin
               if (ddata_w[0]) match_d = 1'b0;
               if (ddata_w[3]) ovf_d   = 1'b0;
               irq_en_d = ddata_w[4];
            end
            default: ;
         endcase
      end

      // Sets are applied after the W1C clears so a coincident set wins
      if (timer_q == cmp_q) match_d = 1'b1;
      if (push_req && !push_ok) ovf_d = 1'b1;

      if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + FIFO_PW'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + FIFO_CW'(1);
         2'b01:   count_d = count_q - FIFO_CW'(1);
         default: count_d = count_q;
      endcase
   end

   // MMIO state registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         gpio_out_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         timer_q    <= '0;
         cmp_q      <= 32'hFFFF_FFFF;
         match_q    <= 1'b0;
         ovf_q      <= 1'b0;
         irq_en_q   <= 1'b0;
         irq_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         gpio_out_q <= gpio_out_d;
         sync1_q    <= gpio_i;
         sync2_q    <= sync1_q;
         timer_q    <= timer_d;
         cmp_q      <= cmp_d;
         match_q    <= match_d;
         ovf_q      <= ovf_d;
         irq_en_q   <= irq_en_d;
         irq_q      <= irq_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Data RAM write port; contents survive reset
   always_ff @(posedge CLK) begin
      if (ram_wr) mem[ram_idx] <= ddata_w;
   end

   // FIFO storage write; gated by reset so a push during reset leaves no trace
   always_ff @(posedge CLK) begin
      if (RSTn && push_ok) fifo_mem[wr_ptr_q] <= ddata_w[7:0];
   end

   // Output drives
   always_comb begin
      gpio_o   = gpio_out_q;
      irq      = irq_q;
      tx_valid = (count_q != '0);
      tx_data  = fifo_mem[rd_ptr_q];
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

   localparam int unsigned GPIO_W = 8;

   logic              CLK = 1'b0;
   logic              RSTn;
   logic [9:0]        daddr;
   logic [31:0]       ddata_w;
   logic              d_w;
   logic              d_r;
   logic [31:0]       ddata_r;
   logic [GPIO_W-1:0] gpio_i;
   logic [GPIO_W-1:0] gpio_o;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              irq;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] drain_exp [4];

   dmem_responder #(.RAM_WORDS(768), .GPIO_W(GPIO_W), .FIFO_DEPTH(4)) dut (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .daddr    (daddr),
      .ddata_w  (ddata_w),
      .d_w      (d_w),
      .d_r      (d_r),
      .ddata_r  (ddata_r),
      .gpio_i   (gpio_i),
      .gpio_o   (gpio_o),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .irq      (irq)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [9:0] a, input logic [31:0] d);
      daddr   = a;
      ddata_w = d;
      d_w     = 1'b1;
      tick();
      d_w     = 1'b0;
   endtask

   task automatic check_rd(input string tag, input logic [9:0] a, input logic [31:0] exp);
      daddr = a;
      d_r   = 1'b1;
      #1;
      check(tag, ddata_r, exp);
      d_r   = 1'b0;
   endtask

   initial begin
      drain_exp[0] = 8'h42;
      drain_exp[1] = 8'h43;
      drain_exp[2] = 8'h44;
      drain_exp[3] = 8'h46;

      RSTn = 1'b0; daddr = '0; ddata_w = '0; d_w = 1'b0; d_r = 1'b0;
      gpio_i = '0; tx_ready = 1'b0;

      // Reset / idle
      tick();
      tick();
      check("rst_gpio_o", 32'(gpio_o), 32'h0);
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check_rd("rst_status", 10'h304, 32'h0000_0004);
      check_rd("rst_cmp", 10'h303, 32'hFFFF_FFFF);
      check_rd("rst_timer", 10'h302, 32'h0);
      RSTn = 1'b1;
      tick();
      check_rd("idle_status", 10'h304, 32'h0000_0004);

      // RAM
      wr(10'h010, 32'hDEAD_BEEF);
      check_rd("ram_rd", 10'h010, 32'hDEAD_BEEF);
      daddr = 10'h2FF; d_r = 1'b0; #1;
      check("ram_dr_low", ddata_r, 32'h0);
      check_rd("mmio_unmapped", 10'h3F0, 32'h0);
      daddr = 10'h010; ddata_w = 32'h1234_5678; d_w = 1'b1; d_r = 1'b1; #1;
      check("ram_collide_old", ddata_r, 32'hDEAD_BEEF);
      tick();
      d_w = 1'b0; d_r = 1'b0;
      check_rd("ram_collide_new", 10'h010, 32'h1234_5678);

      // Timer wrap, compare match and interrupt
      wr(10'h302, 32'hFFFF_FFFE);
      wr(10'h303, 32'h0000_0001);
      wr(10'h304, 32'h0000_0010);
      check_rd("timer_wrap", 10'h302, 32'h0);
      tick();
      check_rd("timer_inc", 10'h302, 32'h1);
      check_rd("status_pre_match", 10'h304, 32'h0000_0014);
      check("irq_pre_match", 32'(irq), 32'h0);
      tick();
      check_rd("status_match", 10'h304, 32'h0000_0015);
      check("irq_lag", 32'(irq), 32'h0);
      tick();
      check("irq_high", 32'(irq), 32'h1);
      wr(10'h304, 32'h0000_0011);
      check("irq_still_high", 32'(irq), 32'h1);
      check_rd("status_w1c", 10'h304, 32'h0000_0014);
      tick();
      check("irq_low", 32'(irq), 32'h0);

      // FIFO fill and overflow
      tx_ready = 1'b0;
      wr(10'h305, 32'h0000_0041);
      check("fifo_valid", 32'(tx_valid), 32'h1);
      check("fifo_head", 32'(tx_data), 32'h41);
      wr(10'h305, 32'h0000_0042);
      wr(10'h305, 32'h0000_0043);
      check_rd("status_3", 10'h304, 32'h0000_0010);
      wr(10'h305, 32'h0000_0044);
      check_rd("status_full", 10'h304, 32'h0000_0012);
      wr(10'h305, 32'h0000_0045);
      check_rd("status_ovf", 10'h304, 32'h0000_001A);
      check("fifo_head_held", 32'(tx_data), 32'h41);
      check_rd("tx_data_reads0", 10'h305, 32'h0);
      wr(10'h304, 32'h0000_0018);
      check_rd("status_ovf_clr", 10'h304, 32'h0000_0012);

      // Simultaneous push and pop while full
      tx_ready = 1'b1;
      wr(10'h305, 32'h0000_0046);
      tx_ready = 1'b0;
      check_rd("status_pushpop", 10'h304, 32'h0000_0012);
      check("head_after_pop", 32'(tx_data), 32'h42);

      // Drain order
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain_%0d", i), 32'(tx_data), 32'(drain_exp[i]));
         tick();
      end
      tx_ready = 1'b0;
      check("drain_empty", 32'(tx_valid), 32'h0);
      check_rd("status_drained", 10'h304, 32'h0000_0014);

      // GPIO
      wr(10'h300, 32'h0000_01A5);
      check("gpio_o", 32'(gpio_o), 32'h0000_00A5);
      check_rd("gpio_out_rd", 10'h300, 32'h0000_00A5);
      gpio_i = 8'h3C;
      tick();
      check_rd("gpio_in_1edge", 10'h301, 32'h0);
      tick();
      check_rd("gpio_in_2edge", 10'h301, 32'h0000_003C);

      // Reset mid-drain
      wr(10'h305, 32'h0000_0055);
      wr(10'h305, 32'h0000_0066);
      tx_ready = 1'b1;
      tick();
      check("middrain_head", 32'(tx_data), 32'h66);
      check("middrain_valid", 32'(tx_valid), 32'h1);
      RSTn = 1'b0;
      tick();
      check("reset_tx_valid", 32'(tx_valid), 32'h0);
      check("reset_gpio_o", 32'(gpio_o), 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      check_rd("reset_status", 10'h304, 32'h0000_0004);
      RSTn = 1'b1;
      tx_ready = 1'b0;
      tick();
      check_rd("ram_kept", 10'h010, 32'h1234_5678);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
